// File: rtl/mcht_enc_frm.sv
// Manchester frame encoder: sync pair, then LEN+1 data bits, then a closing high half.
// A one-deep holding register lets the next frame queue while the current one is on the line.
module mcht_enc_frm #(
  parameter int pMAX_LEN  = 16,
  parameter int pHALF_DIV = 1,
  parameter int pLEN_WID  = $clog2(pMAX_LEN)
) (
  input  logic                CLK_25M,
  input  logic                RST,
  input  logic                IN_VLD,
  output logic                IN_RDY,
  input  logic [pMAX_LEN-1:0] IN_MSG,
  input  logic [pLEN_WID-1:0] IN_LEN,
  input  logic                IN_INV,
  input  logic                IN_MSB,
  output logic                TXD,
  output logic                TXE,
  output logic                BUSY,
  output logic                DONE
);

  localparam int DIV_W = (pHALF_DIV > 1) ? $clog2(pHALF_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(pHALF_DIV - 1);
  localparam logic [pLEN_WID:0] LEN_CAP  = (pLEN_WID + 1)'(pMAX_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SYNC0 = 3'd1,
    S_SYNC1 = 3'd2,
    S_BITA  = 3'd3,
    S_BITB  = 3'd4,
    S_END   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [pLEN_WID-1:0] bit_idx_q, bit_idx_d;
  logic [pLEN_WID-1:0] len_q, len_d;
  logic [pMAX_LEN-1:0] msg_q, msg_d;
  logic                inv_q, inv_d, msb_q, msb_d;
  logic                hold_vld_q, hold_vld_d;
  logic [pMAX_LEN-1:0] hold_msg_q, hold_msg_d;
  logic [pLEN_WID-1:0] hold_len_q, hold_len_d;
  logic                hold_inv_q, hold_inv_d, hold_msb_q, hold_msb_d;
  logic                txd_q, txd_d, txe_q, txe_d, busy_q, busy_d, done_q, done_d;

  logic                wrap_s, accept_s, load_s, cur_bit_s;
  logic [pLEN_WID-1:0] len_in_s, bit_sel_s;

  assign IN_RDY = !hold_vld_q;
  assign TXD    = txd_q;
  assign TXE    = txe_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;

  // Next-state, holding register and registered line outputs (computed from the next state).
  always_comb begin
    wrap_s   = (div_q == DIV_LAST);
    accept_s = IN_VLD && !hold_vld_q;
    if ({1'b0, IN_LEN} > LEN_CAP) len_in_s = LEN_CAP[pLEN_WID-1:0];
    else                          len_in_s = IN_LEN;

    load_s    = 1'b0;
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    if (state_q == S_IDLE || wrap_s) div_d = {DIV_W{1'b0}};
    else                             div_d = div_q + 1'b1;

    case (state_q)
      S_IDLE:  if (hold_vld_q) load_s = 1'b1; else state_d = S_IDLE;
      S_SYNC0: if (wrap_s) state_d = S_SYNC1; else state_d = S_SYNC0;
      S_SYNC1: if (wrap_s) state_d = S_BITA;  else state_d = S_SYNC1;
      S_BITA:  if (wrap_s) state_d = S_BITB;  else state_d = S_BITA;
      S_BITB: begin
        if (!wrap_s) begin
          state_d = S_BITB;
        end else if (bit_idx_q < len_q) begin
          bit_idx_d = bit_idx_q + 1'b1;
          state_d   = S_BITA;
        end else begin
          state_d = S_END;
        end
      end
      S_END: begin
        if (!wrap_s)         state_d = S_END;
        else if (hold_vld_q) load_s  = 1'b1;
        else                 state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (load_s) begin
      state_d   = S_SYNC0;
      bit_idx_d = {pLEN_WID{1'b0}};
      msg_d     = hold_msg_q;
      len_d     = hold_len_q;
      inv_d     = hold_inv_q;
      msb_d     = hold_msb_q;
    end else begin
      msg_d = msg_q;
      len_d = len_q;
      inv_d = inv_q;
      msb_d = msb_q;
    end

    hold_msg_d = hold_msg_q;
    hold_len_d = hold_len_q;
    hold_inv_d = hold_inv_q;
    hold_msb_d = hold_msb_q;
    if (accept_s) begin
      hold_vld_d = 1'b1;
      hold_msg_d = IN_MSG;
      hold_len_d = len_in_s;
      hold_inv_d = IN_INV;
      hold_msb_d = IN_MSB;
    end else if (load_s) begin
      hold_vld_d = 1'b0;
    end else begin
      hold_vld_d = hold_vld_q;
    end

    if (msb_d) bit_sel_s = len_d - bit_idx_d;
    else       bit_sel_s = bit_idx_d;
    cur_bit_s = msg_d[bit_sel_s];

    case (state_d)
      S_IDLE:  begin txd_d = 1'b1;                txe_d = 1'b0; end
      S_SYNC0: begin txd_d = 1'b0;                txe_d = 1'b1; end
      S_SYNC1: begin txd_d = 1'b1;                txe_d = 1'b1; end
      S_BITA:  begin txd_d = ~cur_bit_s ^ inv_d;  txe_d = 1'b1; end
      S_BITB:  begin txd_d = cur_bit_s ^ inv_d;   txe_d = 1'b1; end
      S_END:   begin txd_d = 1'b1;                txe_d = 1'b0; end
      default: begin txd_d = 1'b1;                txe_d = 1'b0; end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_END) && wrap_s;
  end

  // State and output registers; reset aborts any frame and drops the held one.
  always_ff @(posedge CLK_25M or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      div_q      <= {DIV_W{1'b0}};
      bit_idx_q  <= {pLEN_WID{1'b0}};
      len_q      <= {pLEN_WID{1'b0}};
      msg_q      <= {pMAX_LEN{1'b0}};
      inv_q      <= 1'b0;
      msb_q      <= 1'b0;
      hold_vld_q <= 1'b0;
      hold_msg_q <= {pMAX_LEN{1'b0}};
      hold_len_q <= {pLEN_WID{1'b0}};
      hold_inv_q <= 1'b0;
      hold_msb_q <= 1'b0;
      txd_q      <= 1'b1;
      txe_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_idx_q  <= bit_idx_d;
      len_q      <= len_d;
      msg_q      <= msg_d;
      inv_q      <= inv_d;
      msb_q      <= msb_d;
      hold_vld_q <= hold_vld_d;
      hold_msg_q <= hold_msg_d;
      hold_len_q <= hold_len_d;
      hold_inv_q <= hold_inv_d;
      hold_msb_q <= hold_msb_d;
      txd_q      <= txd_d;
      txe_q      <= txe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_mcht_enc_frm.sv
// Bench for mcht_enc_frm: two instances (half-bit of 1 and 3 clocks) share stimulus and are
// compared every cycle against a frame-schedule model; directed vectors cover the corner cases.
module tb_mcht_enc_frm;
  localparam int MAXL = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_vld, in_inv, in_msb;
  logic [15:0] in_msg;
  logic [3:0]  in_len;
  logic rdy1, txd1, txe1, busy1, done1;
  logic rdy3, txd3, txe3, busy3, done3;

  mcht_enc_frm #(.pMAX_LEN(MAXL), .pHALF_DIV(1)) dut1 (
    .CLK_25M(clk), .RST(rst), .IN_VLD(in_vld), .IN_RDY(rdy1), .IN_MSG(in_msg),
    .IN_LEN(in_len), .IN_INV(in_inv), .IN_MSB(in_msb),
    .TXD(txd1), .TXE(txe1), .BUSY(busy1), .DONE(done1));

  mcht_enc_frm #(.pMAX_LEN(MAXL), .pHALF_DIV(3)) dut3 (
    .CLK_25M(clk), .RST(rst), .IN_VLD(in_vld), .IN_RDY(rdy3), .IN_MSG(in_msg),
    .IN_LEN(in_len), .IN_INV(in_inv), .IN_MSB(in_msb),
    .TXD(txd3), .TXE(txe3), .BUSY(busy3), .DONE(done3));

  int errors = 0;
  int checks = 0;

  // Reference model: per instance, the frame on the line and its sample position, plus the held frame.
  int          m_div [2] = '{1, 3};
  bit          m_act [2];
  int          m_pos [2];
  logic [15:0] m_msg [2];
  int          m_len [2];
  bit          m_inv [2];
  bit          m_msb [2];
  bit          m_done[2];
  bit          h_vld [2];
  logic [15:0] h_msg [2];
  int          h_len [2];
  bit          h_inv [2];
  bit          h_msb [2];

  typedef struct {
    logic [15:0] msg;
    logic [3:0]  len;
    bit          inv;
    bit          msb;
    logic [63:0] pat;
    int          n;
  } vec_t;
  vec_t vecs[6];

  function automatic int frame_cycles(input int len, input int div);
    return (2 * (len + 1) + 3) * div;
  endfunction

  function automatic bit line_level(input logic [15:0] msg, input int len, input bit inv,
                                    input bit msb, input int div, input int pos);
    int seg;
    int k;
    bit b;
    seg = pos / div;
    if (seg == 0) return 1'b0;
    if (seg == 1) return 1'b1;
    if (seg == 2 * (len + 1) + 2) return 1'b1;
    k = (seg - 2) / 2;
    b = msb ? msg[len - k] : msg[k];
    return ((seg - 2) % 2 == 0) ? (~b ^ inv) : (b ^ inv);
  endfunction

  task automatic model_step(input int d);
    bit acc;
    bit ended;
    if (rst) begin
      m_act[d] = 1'b0; m_pos[d] = 0; m_done[d] = 1'b0; h_vld[d] = 1'b0;
    end else begin
      acc   = in_vld && !h_vld[d];
      ended = 1'b0;
      if (m_act[d]) begin
        m_pos[d]++;
        if (m_pos[d] == frame_cycles(m_len[d], m_div[d])) begin
          m_act[d] = 1'b0;
          ended    = 1'b1;
        end
      end
      if (!m_act[d] && h_vld[d]) begin
        m_act[d] = 1'b1; m_pos[d] = 0; h_vld[d] = 1'b0;
        m_msg[d] = h_msg[d]; m_len[d] = h_len[d]; m_inv[d] = h_inv[d]; m_msb[d] = h_msb[d];
      end
      if (acc) begin
        h_vld[d] = 1'b1;
        h_msg[d] = in_msg;
        h_len[d] = (int'(in_len) > MAXL - 1) ? MAXL - 1 : int'(in_len);
        h_inv[d] = in_inv;
        h_msb[d] = in_msb;
      end
      m_done[d] = ended;
    end
  endtask

  // {TXD, TXE, BUSY, DONE, IN_RDY}
  function automatic logic [4:0] model_out(input int d);
    bit t, e, b;
    if (m_act[d]) begin
      t = line_level(m_msg[d], m_len[d], m_inv[d], m_msb[d], m_div[d], m_pos[d]);
      e = (m_pos[d] / m_div[d]) != 2 * (m_len[d] + 1) + 2;
      b = 1'b1;
    end else begin
      t = 1'b1; e = 1'b0; b = 1'b0;
    end
    return {t, e, b, m_done[d], !h_vld[d]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    check("dut1_outputs", {txd1, txe1, busy1, done1, rdy1}, model_out(0));
    check("dut3_outputs", {txd3, txe3, busy3, done3, rdy3}, model_out(1));
  endtask

  task automatic wait_idle(input int d);
    for (int i = 0; i < 400; i++) begin
      if (!m_act[d] && !h_vld[d]) return;
      cycle();
    end
    check("wait_idle_timeout", 64'd0, 64'd1);
  endtask

  task automatic offer(input logic [15:0] msg, input logic [3:0] len, input bit inv, input bit msb);
    in_msg = msg; in_len = len; in_inv = inv; in_msb = msb; in_vld = 1'b1;
    cycle();
    in_vld = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [63:0] got;
    got = 64'd0;
    wait_idle(0);
    offer(v.msg, v.len, v.inv, v.msb);
    for (int i = 0; i < v.n; i++) begin
      cycle();
      got[v.n - 1 - i] = txd1;
    end
    check("txd_pattern", got, v.pat);
    cycle();
    check("done_after_end", {63'd0, done1}, 64'd1);
  endtask

  initial begin
    int ndone, nbusy, runlen, bad;
    bit prev, seen;

    // Expected line sequences (TXD per cycle from SYNC0 to the END half), half-bit = 1 clock.
    vecs[0] = '{16'h000A, 4'd3, 1'b0, 1'b0, 64'b01_10_01_10_01_1, 11};
    vecs[1] = '{16'h000A, 4'd3, 1'b1, 1'b1, 64'b01_10_01_10_01_1, 11};
    vecs[2] = '{16'h0003, 4'd3, 1'b1, 1'b1, 64'b01_01_01_10_10_1, 11};
    vecs[3] = '{16'h0001, 4'd0, 1'b0, 1'b0, 64'b01_01_1, 5};
    vecs[4] = '{16'h0002, 4'd1, 1'b0, 1'b1, 64'b01_01_10_1, 7};
    // A requested length of 31 reaches the 4-bit port as 15: a full 16-bit frame.
    vecs[5] = '{16'h8001, 4'(31), 1'b0, 1'b0,
                64'b01_01_10_10_10_10_10_10_10_10_10_10_10_10_10_10_01_1, 35};

    rst = 1'b0; in_vld = 1'b0; in_msg = 16'd0; in_len = 4'd0; in_inv = 1'b0; in_msb = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_dut1", {txd1, txe1, busy1, done1, rdy1}, 5'b10001);
    check("rst_dut3", {txd3, txe3, busy3, done3, rdy3}, 5'b10001);
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Half-bit of 3 clocks, 16-bit frame: 105 busy cycles, every TXD level a multiple of 3.
    wait_idle(1);
    offer(16'hA5C3, 4'd15, 1'b0, 1'b0);
    nbusy = 0; runlen = 0; bad = 0; prev = 1'b0; seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      cycle();
      if (done3) begin
        seen = 1'b1;
      end else if (busy3) begin
        nbusy++;
        if (runlen != 0 && txd3 == prev) begin
          runlen++;
        end else begin
          if (runlen % 3 != 0) bad++;
          prev = txd3;
          runlen = 1;
        end
      end
    end
    if (runlen % 3 != 0) bad++;
    check("div3_done_seen", {63'd0, seen}, 64'd1);
    check("div3_busy_span", nbusy, 64'd105);
    check("div3_run_lengths_bad", bad, 64'd0);

    // Back-to-back: second frame accepted right after the first loads; no IDLE gap.
    wait_idle(0);
    offer(16'h00F0, 4'd7, 1'b0, 1'b0);
    in_msg = 16'h3C5A; in_len = 4'd9; in_inv = 1'b1; in_msb = 1'b1; in_vld = 1'b1;
    cycle();
    cycle();
    in_vld = 1'b0;
    check("rdy_low_after_second", {63'd0, rdy1}, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      cycle();
      if (done1) seen = 1'b1;
    end
    check("b2b_sync0_with_done", {done1, busy1, txe1, txd1}, 4'b1110);
    ndone = seen ? 1 : 0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      cycle();
      if (done1) begin ndone++; seen = 1'b1; end
    end
    check("b2b_two_done", ndone, 64'd2);

    // Reset during BITB of bit 5 with a frame held.
    wait_idle(0);
    offer(16'h0F85, 4'd9, 1'b0, 1'b0);
    in_msg = 16'h1234; in_len = 4'd5; in_vld = 1'b1;
    cycle();
    cycle();
    in_vld = 1'b0;
    for (int i = 0; i < 12; i++) cycle();
    check("bitb5_before_rst", {txd1, txe1}, 2'b01);
    rst = 1'b1;
    #1;
    check("rst_mid_frame", {txd1, txe1, busy1, rdy1}, 4'b1001);
    ndone = 0;
    for (int i = 0; i < 3; i++) begin cycle(); ndone += int'(done1); end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin cycle(); ndone += int'(done1); end
    check("no_done_after_rst", ndone, 64'd0);
    run_vec(vecs[0]);

    // Randomised traffic, including occasional resets, checked cycle by cycle against the model.
    for (int i = 0; i < 4000; i++) begin
      rst    = ($urandom_range(0, 599) == 0);
      in_vld = ($urandom_range(0, 2) != 0);
      in_msg = 16'($urandom);
      in_len = 4'($urandom_range(0, 15));
      in_inv = 1'($urandom_range(0, 1));
      in_msb = 1'($urandom_range(0, 1));
      cycle();
    end
    rst = 1'b0;
    in_vld = 1'b0;
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
